// File: rtl/band_gain_mixer_pkg.sv
// band_gain_mixer_pkg
//   Shared Q-format definitions for the equaliser datapath: sample width,
//   fractional bits, unity / saturation constants, the mixer FSM state
//   encoding and a saturation helper usable by any block that narrows an
//   accumulator back to a sample.
//   No ports (package).
package band_gain_mixer_pkg;

  localparam int WIDTH     = 22;
  localparam int PRESICION = 14;
  localparam int ACC_WIDTH = 2*WIDTH - PRESICION + 2;

  localparam logic [WIDTH-1:0] ONE    = 22'h004000;
  localparam logic [WIDTH-1:0] MAXPOS = 22'h1FFFFF;
  localparam logic [WIDTH-1:0] MAXNEG = 22'h200000;

  // Saturation thresholds expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAXPOS = 32'sd2097151;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAXNEG = -32'sd2097152;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_B = 3'd1,
    MUL_M = 3'd2,
    MUL_A = 3'd3,
    SAT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             clip;
  } sat_t;

  // Clamp an accumulator into the sample range and flag whether it clipped.
  function automatic sat_t sat(input logic signed [ACC_WIDTH-1:0] acc);
    sat_t r;
    if (acc > ACC_MAXPOS) begin
      r.data = MAXPOS;
      r.clip = 1'b1;
    end else if (acc < ACC_MAXNEG) begin
      r.data = MAXNEG;
      r.clip = 1'b1;
    end else begin
      r.data = acc[WIDTH-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mixer_mac_unit.sv
// mixer_mac_unit
//   Combinational multiply / scale / add: acc_out = acc_in + scale(sample*gain).
//   scale() is an arithmetic right shift by Presicion (floor). When the
//   macro MIXER_ROUNDING_EN is defined, half an output LSB is added to the
//   product before the shift (round half up).
// Ports:
//   sample  in  Width     signed band sample
//   gain    in  Width     signed gain
//   acc_in  in  AccWidth  signed running sum
//   acc_out out AccWidth  signed updated sum
module mixer_mac_unit #(
  parameter int Width     = 22,
  parameter int Presicion = 14,
  parameter int AccWidth  = 2*Width - Presicion + 2
) (
  input  logic signed [Width-1:0]    sample,
  input  logic signed [Width-1:0]    gain,
  input  logic signed [AccWidth-1:0] acc_in,
  output logic signed [AccWidth-1:0] acc_out
);

  logic signed [2*Width-1:0] prod_s;
  logic signed [2*Width-1:0] prod_adj_s;
  logic signed [2*Width-1:0] prod_sh_s;
  logic signed [AccWidth-1:0] scaled_s;

  assign prod_s = sample * gain;

`ifdef MIXER_ROUNDING_EN
  localparam logic signed [2*Width-1:0] HALF_LSB =
    {{(2*Width-1){1'b0}}, 1'b1} << (Presicion - 1);
  // The product never comes near full scale, so adding half an LSB cannot wrap.
  assign prod_adj_s = prod_s + HALF_LSB;
`else
  assign prod_adj_s = prod_s;
`endif

  assign prod_sh_s = prod_adj_s >>> Presicion;
  // Shifted product fits well inside the accumulator; truncation keeps the sign.
  assign scaled_s  = AccWidth'(prod_sh_s);
  assign acc_out   = acc_in + scaled_s;

endmodule

// File: rtl/band_gain_mixer.sv
// band_gain_mixer
//   Applies a gain to each of the bass / mid / treble band samples, sums the
//   three products with a single time-shared multiplier and saturates the
//   sum into yk. Capture on an enable edge, result 4 edges later.
//   Build option: MIXER_ROUNDING_EN (round-half-up scaling in mixer_mac_unit).
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   enable                   one-cycle sample strobe
//   ykbajos/ykmedios/ykaltos band samples
//   gain_bajos/_medios/_altos band gains
//   yk, valid, saturado      output sample, update pulse, clip flag
//   busy                     FSM not idle
//   overrun                  sticky: enable seen while busy
module band_gain_mixer
  import band_gain_mixer_pkg::*;
#(
  parameter int Width     = WIDTH,
  parameter int Presicion = PRESICION,
  parameter int AccWidth  = ACC_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [Width-1:0] ykbajos,
  input  logic signed [Width-1:0] ykmedios,
  input  logic signed [Width-1:0] ykaltos,
  input  logic signed [Width-1:0] gain_bajos,
  input  logic signed [Width-1:0] gain_medios,
  input  logic signed [Width-1:0] gain_altos,
  output logic signed [Width-1:0] yk,
  output logic                    valid,
  output logic                    busy,
  output logic                    saturado,
  output logic                    overrun
);

  state_t state_r, state_next_s;

  logic signed [Width-1:0]    b_r, m_r, a_r, gb_r, gm_r, ga_r;
  logic signed [AccWidth-1:0] acc_r;
  logic signed [Width-1:0]    yk_r;
  logic                       valid_r, sat_r, overrun_r;

  logic signed [Width-1:0]    op_sample_s, op_gain_s;
  logic signed [AccWidth-1:0] acc_in_s, acc_out_s;
  sat_t                       sat_s;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state: enable only matters in IDLE; otherwise a fixed sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (enable) state_next_s = MUL_B; else state_next_s = IDLE;
      MUL_B:   state_next_s = MUL_M;
      MUL_M:   state_next_s = MUL_A;
      MUL_A:   state_next_s = SAT;
      SAT:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand select for the shared MAC; the bass step starts from zero.
  always_comb begin
    op_sample_s = b_r;
    op_gain_s   = gb_r;
    acc_in_s    = '0;
    case (state_r)
      MUL_M: begin op_sample_s = m_r; op_gain_s = gm_r; acc_in_s = acc_r; end
      MUL_A: begin op_sample_s = a_r; op_gain_s = ga_r; acc_in_s = acc_r; end
      default: begin op_sample_s = b_r; op_gain_s = gb_r; acc_in_s = '0; end
    endcase
  end

  mixer_mac_unit #(
    .Width     (Width),
    .Presicion (Presicion),
    .AccWidth  (AccWidth)
  ) u_mac (
    .sample  (op_sample_s),
    .gain    (op_gain_s),
    .acc_in  (acc_in_s),
    .acc_out (acc_out_s)
  );

  assign sat_s = sat(acc_r);

  // Input holding registers, loaded only on an accepted strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_r <= '0; m_r <= '0; a_r <= '0;
      gb_r <= '0; gm_r <= '0; ga_r <= '0;
    end else if (state_r == IDLE && enable) begin
      b_r <= ykbajos; m_r <= ykmedios; a_r <= ykaltos;
      gb_r <= gain_bajos; gm_r <= gain_medios; ga_r <= gain_altos;
    end
  end

  // Accumulator: updated during the three multiply steps only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
    end else begin
      case (state_r)
        MUL_B, MUL_M, MUL_A: acc_r <= acc_out_s;
        default:             acc_r <= acc_r;
      endcase
    end
  end

  // Output register, clip flag and single-cycle valid pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      yk_r    <= '0;
      sat_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (state_r == SAT) begin
      yk_r    <= sat_s.data;
      sat_r   <= sat_s.clip;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Sticky overrun: a strobe while busy is dropped and remembered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           overrun_r <= 1'b0;
    else if (enable && state_r != IDLE)  overrun_r <= 1'b1;
  end

  assign yk       = yk_r;
  assign valid    = valid_r;
  assign saturado = sat_r;
  assign overrun  = overrun_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_band_gain_mixer.sv
module tb_band_gain_mixer;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [21:0] ykbajos = '0, ykmedios = '0, ykaltos = '0;
  logic signed [21:0] gain_bajos = '0, gain_medios = '0, gain_altos = '0;
  logic signed [21:0] yk;
  logic               valid, busy, saturado, overrun;

  int checks = 0;
  int errors = 0;

  band_gain_mixer dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ykbajos(ykbajos), .ykmedios(ykmedios), .ykaltos(ykaltos),
    .gain_bajos(gain_bajos), .gain_medios(gain_medios), .gain_altos(gain_altos),
    .yk(yk), .valid(valid), .busy(busy), .saturado(saturado), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [21:0] b, m, a, gb, gm, ga);
    ykbajos = b; ykmedios = m; ykaltos = a;
    gain_bajos = gb; gain_medios = gm; gain_altos = ga;
  endtask

  // Capture one sample and wait (bounded) for its valid pulse.
  task automatic run_sample(input logic [21:0] b, m, a, gb, gm, ga,
                            output logic [21:0] y, output logic s,
                            output int lat, output int bcnt);
    @(negedge clock);
    drive(b, m, a, gb, gm, ga);
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    lat = 0; bcnt = 0;
    while (valid !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
    y = yk; s = saturado;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (yk !== 22'h0) begin errors++; $display("FAIL reset_yk got %h want %h", yk, 22'h0); end
    checks++; if ({valid, busy, saturado, overrun} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want %b", {valid, busy, saturado, overrun}, 4'b0000);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_unity;
    logic [21:0] y; logic s; int lat, bc;
    run_sample(22'h1000, 22'h0800, 22'h0400, 22'h4000, 22'h4000, 22'h4000, y, s, lat, bc);
    checks++; if (y !== 22'h001C00) begin errors++; $display("FAIL unity_yk got %h want %h", y, 22'h001C00); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL unity_sat got %b want 0", s); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL unity_latency got %0d want 4", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL unity_busy_cycles got %0d want 4", bc); end
    @(posedge clock); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL unity_valid_width got %b want 0", valid); end
    checks++; if (yk !== 22'h001C00) begin errors++; $display("FAIL unity_hold got %h want %h", yk, 22'h001C00); end
  endtask

  task automatic test_saturation;
    logic [21:0] y; logic s; int lat, bc;
    run_sample(22'h100000, 22'h100000, 22'h100000, 22'h008000, 22'h008000, 22'h008000, y, s, lat, bc);
    checks++; if (y !== 22'h1FFFFF) begin errors++; $display("FAIL sat_pos_yk got %h want %h", y, 22'h1FFFFF); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b want 1", s); end
    run_sample(22'h300000, 22'h300000, 22'h300000, 22'h004000, 22'h004000, 22'h004000, y, s, lat, bc);
    checks++; if (y !== 22'h200000) begin errors++; $display("FAIL sat_neg_yk got %h want %h", y, 22'h200000); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b want 1", s); end
  endtask

  task automatic test_rounding;
    logic [21:0] y, exp_y; logic s; int lat, bc;
`ifdef MIXER_ROUNDING_EN
    exp_y = 22'h000001;
`else
    exp_y = 22'h000000;
`endif
    run_sample(22'h000001, 22'h000000, 22'h000000, 22'h002000, 22'h000000, 22'h000000, y, s, lat, bc);
    checks++; if (y !== exp_y) begin errors++; $display("FAIL round_yk got %h want %h", y, exp_y); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL round_sat got %b want 0", s); end
  endtask

  task automatic test_overrun;
    logic [21:0] y; logic s; int lat, bc;
    @(negedge clock);
    drive(22'h1000, 22'h0, 22'h0, 22'h4000, 22'h0, 22'h0);
    enable = 1'b1;
    @(posedge clock); #1;              // E
    enable = 1'b0;
    @(posedge clock);                  // E+1
    @(negedge clock);
    drive(22'h0800, 22'h0800, 22'h0800, 22'h4000, 22'h4000, 22'h4000);
    enable = 1'b1;
    @(posedge clock); #1;              // E+2
    enable = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    @(posedge clock);                  // E+3
    @(posedge clock); #1;              // E+4
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", valid); end
    checks++; if (yk !== 22'h001000) begin errors++; $display("FAIL ovr_first_yk got %h want %h", yk, 22'h001000); end
    @(posedge clock); #1;
    checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL ovr_no_second got %b want 00", {valid, busy}); end
    run_sample(22'h0200, 22'h0200, 22'h0200, 22'h4000, 22'h4000, 22'h4000, y, s, lat, bc);
    checks++; if (y !== 22'h000600) begin errors++; $display("FAIL ovr_next_yk got %h want %h", y, 22'h000600); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_async_reset;
    logic [21:0] y; logic s; int lat, bc, vcnt;
    @(negedge clock);
    drive(22'h2000, 22'h0, 22'h0, 22'h4000, 22'h0, 22'h0);
    enable = 1'b1;
    @(posedge clock); #1;              // E
    enable = 1'b0;
    @(posedge clock);                  // E+1
    @(posedge clock); #2;              // just after E+2
    reset = 1'b1;
    #1;
    checks++; if (yk !== 22'h0) begin errors++; $display("FAIL arst_yk got %h want %h", yk, 22'h0); end
    checks++; if ({valid, busy, overrun} !== 3'b000) begin
      errors++; $display("FAIL arst_flags got %b want 000", {valid, busy, overrun});
    end
    @(negedge clock);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (valid === 1'b1) vcnt++;
    end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL arst_no_valid got %0d want 0", vcnt); end
    run_sample(22'h0C00, 22'h0, 22'h0, 22'h4000, 22'h0, 22'h0, y, s, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL arst_latency got %0d want 4", lat); end
    checks++; if (y !== 22'h000C00) begin errors++; $display("FAIL arst_yk_next got %h want %h", y, 22'h000C00); end
  endtask

  task automatic test_back_to_back;
    logic [21:0] y, exp_y; logic s; int lat, bc, npulse;
    npulse = 0;
    for (int n = 1; n <= 10; n++) begin
      exp_y = 22'(n * 'h400);
      run_sample(exp_y, 22'h07FF, 22'h07FF, 22'h4000, 22'h0, 22'h0, y, s, lat, bc);
      if (lat == 4) npulse++;
      checks++; if (y !== exp_y) begin errors++; $display("FAIL b2b_yk_%0d got %h want %h", n, y, exp_y); end
    end
    checks++; if (npulse !== 10) begin errors++; $display("FAIL b2b_pulses got %0d want 10", npulse); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  initial begin
    test_reset;
    test_unity;
    test_saturation;
    test_rounding;
    test_overrun;
    test_async_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
